// File: rtl/shim_spi_cfg_sync_pkg.sv
// Shared definitions for the AXI-to-SPI configuration synchronizer.
package shim_spi_cfg_sync_pkg;

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam int THRESH_W    = 15;
  localparam int WINDOW_W    = 32;
  localparam int LOCKOUT_W   = 32;
  localparam int CAL_W       = 16;
  localparam int N_CH        = 8;
  localparam int CAL_TOTAL_W = CAL_W * N_CH;

endpackage

// File: rtl/shim_cfg_field_sync.sv
// One configuration field: DEPTH-flop synchronizer chain plus a saturating
// stability counter that reports when the chain output has settled.
module shim_cfg_field_sync #(
  parameter int DEPTH        = 3,
  parameter int WIDTH        = 1,
  parameter int STABLE_COUNT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             stable_o
);

  localparam int              CNT_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [WIDTH-1:0] chain_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) chain_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      chain_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
      cnt_q <= cnt_d;
    end
  end

  // Clear on the same edge the chain output takes a new value.
  always_comb begin
    cnt_d = cnt_q;
    if (chain_q[DEPTH-1] != chain_q[DEPTH-2]) cnt_d = '0;
    else if (cnt_q != CNT_MAX)                cnt_d = cnt_q + 1'b1;
  end

  assign dout_o   = chain_q[DEPTH-1];
  assign stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/shim_spi_cfg_sync.sv
// Moves quasi-static AXI configuration into the SPI domain as one coherent
// snapshot, frozen while the SPI system is enabled.
//   state       | meaning
//   ST_WAIT     | no snapshot since reset, outputs at reset values
//   ST_UNLOCKED | snapshot follows settled inputs
//   ST_LOCKED   | spi_en captured high, snapshot frozen, changes flagged
module shim_spi_cfg_sync
  import shim_spi_cfg_sync_pkg::*;
#(
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic                   spi_clk,
  input  logic                   spi_resetn,
  input  logic                   spi_en,
  input  logic                   integ_en,
  input  logic [THRESH_W-1:0]    integ_thresh_avg,
  input  logic [WINDOW_W-1:0]    integ_window,
  input  logic [LOCKOUT_W-1:0]   trig_lockout,
  input  logic [CAL_TOTAL_W-1:0] dac_cal_val,
  output logic                   spi_en_sync,
  output logic                   integ_en_sync,
  output logic [THRESH_W-1:0]    integ_thresh_avg_sync,
  output logic [WINDOW_W-1:0]    integ_window_sync,
  output logic [LOCKOUT_W-1:0]   trig_lockout_sync,
  output logic [CAL_TOTAL_W-1:0] dac_cal_val_sync,
  output logic                   cfg_valid,
  output logic                   cfg_update,
  output logic                   cfg_change_err
);

  logic                   en_s, ie_s;
  logic [THRESH_W-1:0]    th_s;
  logic [WINDOW_W-1:0]    win_s;
  logic [LOCKOUT_W-1:0]   lo_s;
  logic [CAL_TOTAL_W-1:0] cal_s;
  logic [5:0]             stable, diff;
  logic                   all_stable;

  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(1), .STABLE_COUNT(STABLE_COUNT)) u_en (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(spi_en), .dout_o(en_s), .stable_o(stable[0]));
  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(1), .STABLE_COUNT(STABLE_COUNT)) u_ie (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(integ_en), .dout_o(ie_s), .stable_o(stable[1]));
  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(THRESH_W), .STABLE_COUNT(STABLE_COUNT)) u_th (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(integ_thresh_avg), .dout_o(th_s), .stable_o(stable[2]));
  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(WINDOW_W), .STABLE_COUNT(STABLE_COUNT)) u_win (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(integ_window), .dout_o(win_s), .stable_o(stable[3]));
  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(LOCKOUT_W), .STABLE_COUNT(STABLE_COUNT)) u_lo (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(trig_lockout), .dout_o(lo_s), .stable_o(stable[4]));
  shim_cfg_field_sync #(.DEPTH(DEPTH), .WIDTH(CAL_TOTAL_W), .STABLE_COUNT(STABLE_COUNT)) u_cal (
    .clk_i(spi_clk), .rst_ni(spi_resetn), .din_i(dac_cal_val), .dout_o(cal_s), .stable_o(stable[5]));

  state_e                 state_q, state_d;
  logic                   en_q, en_d, ie_q, ie_d;
  logic [THRESH_W-1:0]    th_q, th_d;
  logic [WINDOW_W-1:0]    win_q, win_d;
  logic [LOCKOUT_W-1:0]   lo_q, lo_d;
  logic [CAL_TOTAL_W-1:0] cal_q, cal_d;
  logic                   valid_q, valid_d, upd_q, upd_d, err_q, err_d;

  assign all_stable = &stable;
  assign diff = {cal_s != cal_q, lo_s != lo_q, win_s != win_q,
                 th_s != th_q, ie_s != ie_q, en_s != en_q};

  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      state_q <= ST_WAIT;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      th_q    <= '0;
      win_q   <= '0;
      lo_q    <= '0;
      cal_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      th_q    <= th_d;
      win_q   <= win_d;
      lo_q    <= lo_d;
      cal_q   <= cal_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    ie_d    = ie_q;
    th_d    = th_q;
    win_d   = win_q;
    lo_d    = lo_q;
    cal_d   = cal_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_WAIT: begin
        if (all_stable) begin
          en_d = en_s; ie_d = ie_s; th_d = th_s; win_d = win_s; lo_d = lo_s; cal_d = cal_s;
          upd_d   = 1'b1;
          valid_d = 1'b1;
          state_d = en_s ? ST_LOCKED : ST_UNLOCKED;
        end
      end
      ST_UNLOCKED: begin
        // Holding off one cycle after a pulse keeps cfg_update from running back to back.
        if (all_stable && (|diff) && !upd_q) begin
          en_d = en_s; ie_d = ie_s; th_d = th_s; win_d = win_s; lo_d = lo_s; cal_d = cal_s;
          upd_d = 1'b1;
          if (en_s) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (|(stable[5:1] & diff[5:1])) err_d = 1'b1;
        if (stable[0] && !en_s) begin
          en_d  = 1'b0;
          upd_d = 1'b1;
          if (all_stable) begin
            ie_d = ie_s; th_d = th_s; win_d = win_s; lo_d = lo_s; cal_d = cal_s;
          end
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign spi_en_sync           = en_q;
  assign integ_en_sync         = ie_q;
  assign integ_thresh_avg_sync = th_q;
  assign integ_window_sync     = win_q;
  assign trig_lockout_sync     = lo_q;
  assign dac_cal_val_sync      = cal_q;
  assign cfg_valid             = valid_q;
  assign cfg_update            = upd_q;
  assign cfg_change_err        = err_q;

endmodule

// File: tb/tb_shim_spi_cfg_sync.sv
// Scoreboard bench: an input-history reference model predicts snapshots and
// flags; a separate monitor compares them with the DUT every cycle.
module tb_shim_spi_cfg_sync;
  localparam int DEPTH = 3, STABLE_COUNT = 2, MAXE = 4096;

  logic          spi_clk = 1'b0, spi_resetn = 1'b1;
  logic          spi_en = 1'b0, integ_en = 1'b0;
  logic [14:0]   integ_thresh_avg = '0;
  logic [31:0]   integ_window = '0, trig_lockout = '0;
  logic [127:0]  dac_cal_val = '0;
  logic          spi_en_sync, integ_en_sync, cfg_valid, cfg_update, cfg_change_err;
  logic [14:0]   integ_thresh_avg_sync;
  logic [31:0]   integ_window_sync, trig_lockout_sync;
  logic [127:0]  dac_cal_val_sync;

  shim_spi_cfg_sync #(.DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) dut (
    .spi_clk(spi_clk), .spi_resetn(spi_resetn), .spi_en(spi_en), .integ_en(integ_en),
    .integ_thresh_avg(integ_thresh_avg), .integ_window(integ_window),
    .trig_lockout(trig_lockout), .dac_cal_val(dac_cal_val),
    .spi_en_sync(spi_en_sync), .integ_en_sync(integ_en_sync),
    .integ_thresh_avg_sync(integ_thresh_avg_sync), .integ_window_sync(integ_window_sync),
    .trig_lockout_sync(trig_lockout_sync), .dac_cal_val_sync(dac_cal_val_sync),
    .cfg_valid(cfg_valid), .cfg_update(cfg_update), .cfg_change_err(cfg_change_err));

  always #5 spi_clk = ~spi_clk;

  typedef struct packed {
    logic en; logic ie; logic [14:0] th; logic [31:0] win; logic [31:0] lo; logic [127:0] cal;
  } cfg_t;
  typedef struct { int edge_id; cfg_t snap; } exp_t;

  cfg_t cur_in, dut_out;
  assign cur_in  = {spi_en, integ_en, integ_thresh_avg, integ_window, trig_lockout, dac_cal_val};
  assign dut_out = {spi_en_sync, integ_en_sync, integ_thresh_avg_sync, integ_window_sync,
                    trig_lockout_sync, dac_cal_val_sync};

  exp_t sb[$];
  cfg_t smp [MAXE];
  cfg_t m_held = '0;
  int   m_mode = 0, edge_n = 0;
  logic m_err = 1'b0, m_upd_prev = 1'b0;
  int   checks = 0, errors = 0;

  function automatic logic [127:0] fld(cfg_t c, int f);
    case (f)
      0: return 128'(c.en);
      1: return 128'(c.ie);
      2: return 128'(c.th);
      3: return 128'(c.win);
      4: return 128'(c.lo);
      default: return c.cal;
    endcase
  endfunction

  // Input sampled at edge k (edges counted from 1 after reset release); zero before.
  function automatic cfg_t samp(int k);
    if (k <= 0 || k >= MAXE) return '0;
    return smp[k];
  endfunction

  // Settled after edge m: the synchronized value (input from DEPTH-1 edges back)
  // has been the same for STABLE_COUNT further edges, and enough edges since reset.
  function automatic logic fstable(int f, int m);
    logic [127:0] v;
    if (m < STABLE_COUNT) return 1'b0;
    v = fld(samp(m - DEPTH + 1), f);
    for (int j = 1; j <= STABLE_COUNT; j++)
      if (fld(samp(m - DEPTH + 1 - j), f) != v) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: decides at each edge whether a snapshot is published.
  initial begin : model
    logic st [6];
    logic all_st, upd;
    cfg_t vs;
    int   m;
    forever begin
      @(posedge spi_clk or negedge spi_resetn);
      if (!spi_resetn) begin
        edge_n = 0; m_mode = 0; m_held = '0; m_err = 1'b0; m_upd_prev = 1'b0;
        sb.delete();
      end else begin
        edge_n++;
        if (edge_n < MAXE) smp[edge_n] = cur_in;
        m  = edge_n - 1;
        vs = samp(m - DEPTH + 1);
        all_st = 1'b1;
        for (int f = 0; f < 6; f++) begin
          st[f]  = fstable(f, m);
          all_st = all_st & st[f];
        end
        upd = 1'b0;
        if (m_mode == 0) begin
          if (all_st) begin
            m_held = vs; upd = 1'b1; m_mode = vs.en ? 2 : 1;
          end
        end else if (m_mode == 1) begin
          if (all_st && !m_upd_prev && vs != m_held) begin
            m_held = vs; upd = 1'b1;
            if (vs.en) m_mode = 2;
          end
        end else begin
          for (int f = 1; f < 6; f++)
            if (st[f] && fld(vs, f) != fld(m_held, f)) m_err = 1'b1;
          if (st[0] && !vs.en) begin
            if (all_st) m_held = vs;
            else m_held.en = 1'b0;
            upd = 1'b1; m_mode = 1;
          end
        end
        m_upd_prev = upd;
        if (upd) sb.push_back('{edge_id: edge_n, snap: m_held});
      end
    end
  end

  initial begin : monitor
    cfg_t last_snap;
    logic seen, exp_upd;
    exp_t e;
    last_snap = '0; seen = 1'b0;
    forever begin
      @(negedge spi_clk or negedge spi_resetn);
      #1;
      if (!spi_resetn) begin
        last_snap = '0; seen = 1'b0;
        checks++;
        if (dut_out !== '0 || cfg_valid !== 1'b0 || cfg_update !== 1'b0 || cfg_change_err !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs t=%0t got out=%h valid=%b upd=%b err=%b want all 0",
                   $time, dut_out, cfg_valid, cfg_update, cfg_change_err);
        end
      end else begin
        exp_upd = (sb.size() > 0) && (sb[0].edge_id == edge_n);
        checks++;
        if (cfg_update !== exp_upd) begin
          errors++;
          $display("FAIL cfg_update edge=%0d got %b want %b", edge_n, cfg_update, exp_upd);
        end
        if (exp_upd) begin
          e = sb.pop_front();
          last_snap = e.snap;
          seen = 1'b1;
        end
        checks++;
        if (dut_out !== last_snap) begin
          errors++;
          $display("FAIL snapshot edge=%0d got %h want %h", edge_n, dut_out, last_snap);
        end
        checks++;
        if (cfg_valid !== seen || cfg_change_err !== m_err) begin
          errors++;
          $display("FAIL flags edge=%0d got valid=%b err=%b want valid=%b err=%b",
                   edge_n, cfg_valid, cfg_change_err, seen, m_err);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge spi_clk);
  endtask

  initial begin : stim
    int r, ch;
    logic [31:0] tmp;
    #1 spi_resetn = 1'b0;
    integ_window = 32'd1000;
    integ_thresh_avg = 15'h1234;
    cyc(2);
    spi_resetn = 1'b1;
    cyc(10);
    trig_lockout = 32'd50; cyc(1); trig_lockout = 32'd0; cyc(12);
    trig_lockout = 32'd50; cyc(10);
    spi_en = 1'b1; dac_cal_val[63:48] = 16'h8001; cyc(10);
    integ_window = 32'd2000; cyc(10);
    spi_en = 1'b0; cyc(10);
    repeat (20) begin integ_en = ~integ_en; cyc(1); end
    cyc(10);
    spi_en = 1'b1; cyc(10);
    @(posedge spi_clk); #2 spi_resetn = 1'b0;
    cyc(2);
    spi_resetn = 1'b1;
    cyc(10);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0: spi_en = ~spi_en;
        1: integ_en = ~integ_en;
        2: integ_thresh_avg = 15'($urandom);
        3: integ_window = $urandom;
        4: trig_lockout = $urandom;
        5: begin ch = int'($urandom_range(0, 7)); dac_cal_val[ch*16 +: 16] = 16'($urandom); end
        6: begin tmp = integ_window; integ_window = $urandom; cyc(1); integ_window = tmp; end
        default: ;
      endcase
      cyc(int'($urandom_range(1, 4)));
    end
    cyc(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
